// File: rtl/wb_mailbox_slave.sv
// Wishbone mailbox responder: DATA/STATUS register pair in front of a host-to-fabric
// FIFO (filled by bridge writes) and a fabric-to-host FIFO (drained by bridge reads).
module wb_mailbox_slave #(
    parameter int DEPTH = 8
) (
    input  logic        clk_clk,
    input  logic        reset_reset_n,
    input  logic        wb_address,
    input  logic [31:0] wb_writedata,
    output logic [31:0] wb_readdata,
    input  logic        wb_writeenable,
    input  logic [3:0]  wb_selectarray,
    input  logic        wb_strobe,
    output logic        wb_acknowledge,
    output logic [31:0] h2f_data,
    output logic        h2f_valid,
    input  logic        h2f_ready,
    input  logic [31:0] f2h_data,
    input  logic        f2h_valid,
    output logic        f2h_ready
);

    localparam int CW = $clog2(DEPTH) + 1;
    localparam int PW = $clog2(DEPTH);
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    typedef enum logic {
        S_IDLE = 1'b0,
        S_ACK  = 1'b1
    } state_t;

    // Bridge handshake: a transfer is accepted when wb_strobe is seen in IDLE; the
    // access takes effect on that edge and wb_acknowledge is high for the single
    // following cycle together with wb_readdata. wb_strobe is ignored while acking.
    state_t      state_q;
    logic        ack_q;
    logic [31:0] rdata_q;

    logic [31:0]   h2f_mem [DEPTH];
    logic [31:0]   f2h_mem [DEPTH];
    logic [PW-1:0] h2f_wptr_q, h2f_wptr_d, h2f_rptr_q, h2f_rptr_d;
    logic [PW-1:0] f2h_wptr_q, f2h_wptr_d, f2h_rptr_q, f2h_rptr_d;
    logic [CW-1:0] h2f_cnt_q, h2f_cnt_d, f2h_cnt_q, f2h_cnt_d;
    logic          ovf_q, ovf_d, unf_q, unf_d;

    logic        wb_acc, data_wr, data_rd, stat_wr;
    logic        h2f_full, h2f_empty, f2h_full, f2h_empty;
    logic        h2f_push, h2f_pop, f2h_push, f2h_pop, flush;
    logic [31:0] wr_masked, status_word, rd_val;

    assign wb_acc  = (state_q == S_IDLE) && wb_strobe;
    assign data_wr = wb_acc &&  wb_writeenable && !wb_address;
    assign data_rd = wb_acc && !wb_writeenable && !wb_address;
    assign stat_wr = wb_acc &&  wb_writeenable &&  wb_address;

    assign h2f_full  = (h2f_cnt_q == FULL_CNT);
    assign h2f_empty = (h2f_cnt_q == '0);
    assign f2h_full  = (f2h_cnt_q == FULL_CNT);
    assign f2h_empty = (f2h_cnt_q == '0);

    // All full/empty decisions below use start-of-cycle state only.
    assign h2f_push = data_wr && !h2f_full;
    assign h2f_pop  = h2f_ready && !h2f_empty;
    assign f2h_push = f2h_valid && !f2h_full;
    assign f2h_pop  = data_rd && !f2h_empty;
    assign flush    = stat_wr && wb_selectarray[1] && wb_writedata[8];

    always_comb begin
        wr_masked = '0;
        for (int i = 0; i < 4; i++) begin
            wr_masked[8*i +: 8] = wb_selectarray[i] ? wb_writedata[8*i +: 8] : 8'h00;
        end
    end

    assign status_word = {10'd0, unf_q, ovf_q, f2h_empty, f2h_full, h2f_empty, h2f_full,
                          8'(f2h_cnt_q), 8'(h2f_cnt_q)};

    always_comb begin
        rd_val = '0;
        if (wb_address) begin
            rd_val = status_word;
        end else if (!f2h_empty) begin
            rd_val = f2h_mem[f2h_rptr_q];
        end
    end

    always_comb begin
        h2f_wptr_d = h2f_wptr_q;
        h2f_rptr_d = h2f_rptr_q;
        h2f_cnt_d  = h2f_cnt_q;
        f2h_wptr_d = f2h_wptr_q;
        f2h_rptr_d = f2h_rptr_q;
        f2h_cnt_d  = f2h_cnt_q;
        if (h2f_push) h2f_wptr_d = h2f_wptr_q + 1'b1;
        if (h2f_pop)  h2f_rptr_d = h2f_rptr_q + 1'b1;
        if (f2h_push) f2h_wptr_d = f2h_wptr_q + 1'b1;
        if (f2h_pop)  f2h_rptr_d = f2h_rptr_q + 1'b1;
        if (h2f_push && !h2f_pop) h2f_cnt_d = h2f_cnt_q + 1'b1;
        if (!h2f_push && h2f_pop) h2f_cnt_d = h2f_cnt_q - 1'b1;
        if (f2h_push && !f2h_pop) f2h_cnt_d = f2h_cnt_q + 1'b1;
        if (!f2h_push && f2h_pop) f2h_cnt_d = f2h_cnt_q - 1'b1;
        // Flush wins over any same-cycle push or pop on either FIFO.
        if (flush) begin
            h2f_wptr_d = '0;
            h2f_rptr_d = '0;
            h2f_cnt_d  = '0;
            f2h_wptr_d = '0;
            f2h_rptr_d = '0;
            f2h_cnt_d  = '0;
        end
    end

    always_comb begin
        ovf_d = ovf_q;
        unf_d = unf_q;
        if (data_wr && h2f_full)  ovf_d = 1'b1;
        if (data_rd && f2h_empty) unf_d = 1'b1;
        if (stat_wr && wb_selectarray[0] && wb_writedata[0]) ovf_d = 1'b0;
        if (stat_wr && wb_selectarray[0] && wb_writedata[1]) unf_d = 1'b0;
    end

    always_ff @(posedge clk_clk) begin
        if (!reset_reset_n) begin
            state_q <= S_IDLE;
            ack_q   <= 1'b0;
            rdata_q <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (wb_strobe) begin
                        state_q <= S_ACK;
                        ack_q   <= 1'b1;
                        rdata_q <= wb_writeenable ? 32'd0 : rd_val;
                    end else begin
                        ack_q   <= 1'b0;
                        rdata_q <= '0;
                    end
                end
                S_ACK: begin
                    state_q <= S_IDLE;
                    ack_q   <= 1'b0;
                    rdata_q <= '0;
                end
                default: begin
                    state_q <= S_IDLE;
                    ack_q   <= 1'b0;
                    rdata_q <= '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk_clk) begin
        if (!reset_reset_n) begin
            h2f_wptr_q <= '0;
            h2f_rptr_q <= '0;
            h2f_cnt_q  <= '0;
            f2h_wptr_q <= '0;
            f2h_rptr_q <= '0;
            f2h_cnt_q  <= '0;
            ovf_q      <= 1'b0;
            unf_q      <= 1'b0;
        end else begin
            h2f_wptr_q <= h2f_wptr_d;
            h2f_rptr_q <= h2f_rptr_d;
            h2f_cnt_q  <= h2f_cnt_d;
            f2h_wptr_q <= f2h_wptr_d;
            f2h_rptr_q <= f2h_rptr_d;
            f2h_cnt_q  <= f2h_cnt_d;
            ovf_q      <= ovf_d;
            unf_q      <= unf_d;
        end
    end

    // Storage needs no reset: contents are unreachable once the pointers clear.
    always_ff @(posedge clk_clk) begin
        if (h2f_push) h2f_mem[h2f_wptr_q] <= wr_masked;
        if (f2h_push) f2h_mem[f2h_wptr_q] <= f2h_data;
    end

    assign wb_acknowledge = ack_q;
    assign wb_readdata    = rdata_q;
    assign h2f_data       = h2f_mem[h2f_rptr_q];
    assign h2f_valid      = !h2f_empty;
    assign f2h_ready      = !f2h_full;

endmodule

// File: tb/tb_wb_mailbox_slave.sv
// Bench for wb_mailbox_slave: directed mailbox scenarios followed by random traffic,
// every cycle compared against a queue-based model of the two FIFOs and flags.
module tb_wb_mailbox_slave;

  localparam int DEPTH = 8;

  logic        clk;
  logic        rst_n;
  logic        wb_address;
  logic [31:0] wb_writedata;
  logic [31:0] wb_readdata;
  logic        wb_writeenable;
  logic [3:0]  wb_selectarray;
  logic        wb_strobe;
  logic        wb_acknowledge;
  logic [31:0] h2f_data;
  logic        h2f_valid;
  logic        h2f_ready;
  logic [31:0] f2h_data;
  logic        f2h_valid;
  logic        f2h_ready;

  wb_mailbox_slave #(.DEPTH(DEPTH)) dut (
    .clk_clk        (clk),
    .reset_reset_n  (rst_n),
    .wb_address     (wb_address),
    .wb_writedata   (wb_writedata),
    .wb_readdata    (wb_readdata),
    .wb_writeenable (wb_writeenable),
    .wb_selectarray (wb_selectarray),
    .wb_strobe      (wb_strobe),
    .wb_acknowledge (wb_acknowledge),
    .h2f_data       (h2f_data),
    .h2f_valid      (h2f_valid),
    .h2f_ready      (h2f_ready),
    .f2h_data       (f2h_data),
    .f2h_valid      (f2h_valid),
    .f2h_ready      (f2h_ready)
  );

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // scoreboard state
  int n_checks = 0;
  int n_fail   = 0;
  logic [31:0] m_h2f[$];
  logic [31:0] m_f2h[$];
  bit          m_ovf, m_unf, m_busy, m_ack;
  logic [31:0] m_rdata;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Reference model: applies one clock edge using the inputs present at that edge.
  task automatic model_edge();
    bit          acc, flush;
    int          h_n, f_n;
    logic [31:0] rd, status, masked;
    if (!rst_n) begin
      m_h2f.delete();
      m_f2h.delete();
      m_ovf = 0; m_unf = 0; m_busy = 0; m_ack = 0; m_rdata = 0;
      return;
    end
    acc   = !m_busy && wb_strobe;
    flush = 0;
    rd    = 0;
    h_n   = m_h2f.size();
    f_n   = m_f2h.size();
    status = h_n + (f_n * 256)
           + ((h_n == DEPTH) ? 32'h1 << 16 : 0) + ((h_n == 0) ? 32'h1 << 17 : 0)
           + ((f_n == DEPTH) ? 32'h1 << 18 : 0) + ((f_n == 0) ? 32'h1 << 19 : 0)
           + (m_ovf ? 32'h1 << 20 : 0) + (m_unf ? 32'h1 << 21 : 0);
    masked = 0;
    for (int i = 0; i < 4; i++)
      if (wb_selectarray[i]) masked[8*i +: 8] = wb_writedata[8*i +: 8];
    if (h2f_ready && h_n > 0) void'(m_h2f.pop_front());
    if (acc) begin
      if (wb_writeenable) begin
        if (!wb_address) begin
          if (h_n == DEPTH) m_ovf = 1;
          else m_h2f.push_back(masked);
        end else begin
          if (wb_selectarray[0] && wb_writedata[0]) m_ovf = 0;
          if (wb_selectarray[0] && wb_writedata[1]) m_unf = 0;
          if (wb_selectarray[1] && wb_writedata[8]) flush = 1;
        end
      end else begin
        if (wb_address) rd = status;
        else if (f_n == 0) m_unf = 1;
        else rd = m_f2h.pop_front();
      end
    end
    if (f2h_valid && f_n < DEPTH) m_f2h.push_back(f2h_data);
    if (flush) begin
      m_h2f.delete();
      m_f2h.delete();
    end
    m_busy  = acc;
    m_ack   = acc;
    m_rdata = rd;
  endtask

  task automatic compare();
    check("ack", 32'(wb_acknowledge), 32'(m_ack));
    check("readdata", wb_readdata, m_rdata);
    check("h2f_valid", 32'(h2f_valid), 32'(m_h2f.size() > 0));
    if (m_h2f.size() > 0) check("h2f_data", h2f_data, m_h2f[0]);
    check("f2h_ready", 32'(f2h_ready), 32'(m_f2h.size() < DEPTH));
  endtask

  // driver tasks
  task automatic step();
    @(posedge clk);
    #1;
    model_edge();
    compare();
  endtask

  task automatic wb_xfer(input logic we, input logic addr, input logic [31:0] d,
                         input logic [3:0] sel, output logic [31:0] rd);
    wb_strobe      = 1'b1;
    wb_writeenable = we;
    wb_address     = addr;
    wb_writedata   = d;
    wb_selectarray = sel;
    step();
    rd = wb_readdata;
    wb_strobe = 1'b0;
    step();
  endtask

  initial begin
    logic [31:0] rd;
    int n_acks, n_consec;
    logic prev_ack;
    rst_n = 1'b0; wb_address = 0; wb_writedata = 0; wb_writeenable = 0;
    wb_selectarray = 0; wb_strobe = 0; h2f_ready = 0; f2h_data = 0; f2h_valid = 0;
    repeat (3) step();
    rst_n = 1'b1;
    step();
    wb_xfer(0, 1, 0, 4'hF, rd);
    check("reset_status", rd, 32'h000A_0000);

    // single write, FWFT head, pop
    wb_xfer(1, 0, 32'hDEAD_BEEF, 4'hF, rd);
    check("h2f_head", h2f_data, 32'hDEAD_BEEF);
    wb_xfer(0, 1, 0, 4'hF, rd);
    check("h2f_cnt1", 32'(rd[7:0]), 1);
    h2f_ready = 1; step(); h2f_ready = 0;
    wb_xfer(0, 1, 0, 4'hF, rd);
    check("h2f_empty", 32'(rd[17]), 1);

    // byte lanes
    wb_xfer(1, 0, 32'h1234_5678, 4'b0101, rd);
    check("lane_mask", h2f_data, 32'h0034_0078);
    h2f_ready = 1; step(); h2f_ready = 0;

    // fill, overflow, W1C
    for (int i = 0; i < DEPTH; i++) wb_xfer(1, 0, $urandom, 4'hF, rd);
    wb_xfer(1, 0, 32'hFFFF_FFFF, 4'hF, rd);
    wb_xfer(0, 1, 0, 4'hF, rd);
    check("h2f_full", 32'(rd[16]), 1);
    check("ovf_set", 32'(rd[20]), 1);
    check("h2f_cntD", 32'(rd[7:0]), DEPTH);
    wb_xfer(1, 1, 32'h1, 4'hF, rd);
    wb_xfer(0, 1, 0, 4'hF, rd);
    check("ovf_clr", 32'(rd[20]), 0);
    h2f_ready = 1; repeat (DEPTH) step(); h2f_ready = 0;

    // f2h reads and underflow
    f2h_valid = 1; f2h_data = 32'hA5A5_A5A5; step();
    f2h_data = 32'h5A5A_5A5A; step();
    f2h_valid = 0;
    wb_xfer(0, 0, 0, 4'hF, rd);
    check("f2h_rd0", rd, 32'hA5A5_A5A5);
    wb_xfer(0, 0, 0, 4'hF, rd);
    check("f2h_rd1", rd, 32'h5A5A_5A5A);
    wb_xfer(0, 0, 0, 4'hF, rd);
    check("f2h_rd_empty", rd, 32'h0);
    wb_xfer(0, 1, 0, 4'hF, rd);
    check("unf_set", 32'(rd[21]), 1);
    wb_xfer(1, 1, 32'h2, 4'hF, rd);

    // strobe held high for six cycles
    wb_strobe = 1; wb_writeenable = 1; wb_address = 0; wb_selectarray = 4'hF;
    wb_writedata = 32'hCAFE_0001;
    n_acks = 0; n_consec = 0; prev_ack = 0;
    for (int i = 0; i < 6; i++) begin
      step();
      if (wb_acknowledge) n_acks++;
      if (wb_acknowledge && prev_ack) n_consec++;
      prev_ack = wb_acknowledge;
    end
    wb_strobe = 0;
    check("burst_acks", 32'(n_acks), 3);
    check("burst_consec", 32'(n_consec), 0);
    wb_xfer(0, 1, 0, 4'hF, rd);
    check("burst_cnt", 32'(rd[7:0]), 3);

    // flush with simultaneous fabric pop
    wb_strobe = 1; wb_writeenable = 1; wb_address = 1; wb_selectarray = 4'h2;
    wb_writedata = 32'h100; h2f_ready = 1;
    step();
    wb_strobe = 0; h2f_ready = 0;
    check("flush_valid", 32'(h2f_valid), 0);
    step();
    wb_xfer(0, 1, 0, 4'hF, rd);
    check("flush_cnts", rd[15:0], 0);

    // reset while acking
    wb_strobe = 1; wb_writeenable = 0; wb_address = 1;
    step();
    wb_strobe = 0; rst_n = 0;
    step();
    check("rst_ack", 32'(wb_acknowledge), 0);
    check("rst_rdata", wb_readdata, 0);
    rst_n = 1;
    step();

    // random traffic
    for (int i = 0; i < 800; i++) begin
      wb_strobe      = ($urandom_range(0, 1) == 1);
      wb_writeenable = ($urandom_range(0, 1) == 1);
      wb_address     = ($urandom_range(0, 3) == 0);
      wb_selectarray = 4'($urandom_range(0, 15));
      wb_writedata   = $urandom;
      if (wb_address && $urandom_range(0, 7) != 0) wb_writedata[8] = 1'b0;
      h2f_ready      = ($urandom_range(0, 2) == 0);
      f2h_valid      = ($urandom_range(0, 1) == 1);
      f2h_data       = $urandom;
      rst_n          = ($urandom_range(0, 299) != 0);
      step();
    end
    rst_n = 1;

    // final report
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
